// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
  } entry_t;

  // A PC is fetchable only when word aligned and inside the populated memory.
  function automatic logic pc_is_legal(input logic [ADDR_W-1:0] pc,
                                       input logic [ADDR_W-1:0] words);
    logic [ADDR_W-1:0] idx;
    idx = {2'b00, pc[ADDR_W-1:2]};
    return (pc[1:0] == 2'b00) && (idx < words);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Circular prefetch FIFO with flush; the head entry is presented from registers.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  entry_t                       wr_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output entry_t                       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             mem_r [DEPTH];
  entry_t             head_r;
  logic               head_valid_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               do_push_s;
  logic               do_pop_s;

  // Qualify requests and compute next read pointer and occupancy.
  always_comb begin
    do_pop_s     = pop && !flush && (count_r != '0);
    do_push_s    = push && !flush && ((count_r < CNT_W'(DEPTH)) || do_pop_s);
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      count_nxt_s = '0;
    end else begin
      if (do_pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_nxt_s = count_r + 1'b1;
        2'b01:   count_nxt_s = count_r - 1'b1;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Storage, pointers and the registered head copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      head_r       <= '0;
      head_valid_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
      end
      if (flush) begin
        wr_ptr_r <= rd_ptr_r;
      end else if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      head_valid_r <= (count_nxt_s != '0);
      // The entry landing in the next head slot this cycle bypasses storage.
      if (count_nxt_s != '0) begin
        head_r <= (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) ? wr_entry
                                                           : mem_r[rd_ptr_nxt_s];
      end
    end
  end

  assign count      = count_r;
  assign head_valid = head_valid_r;
  assign head       = head_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, fetch FSM, legality check and prefetch buffer.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                MEM_WORDS = 56,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int                CNT_W       = $clog2(BUF_DEPTH+1);
  localparam logic [ADDR_W-1:0] MEM_WORDS_W = ADDR_W'(MEM_WORDS);

  state_t             state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               fault_r;
  logic               pc_legal_s;
  logic               pop_s;
  logic               push_s;
  logic               space_s;
  logic [CNT_W-1:0]   buf_count_s;
  logic               head_valid_s;
  entry_t             head_s;
  entry_t             wr_entry_s;

  // Handshake and push decision; a redirect suppresses both push and pop.
  always_comb begin
    pc_legal_s      = pc_is_legal(pc_r, MEM_WORDS_W);
    pop_s           = head_valid_s && inst_ready && !redirect_valid;
    space_s         = (buf_count_s < CNT_W'(BUF_DEPTH)) || pop_s;
    wr_entry_s.pc   = pc_r;
    wr_entry_s.data = imem_data;
    if ((state_r == FETCH) && fetch_en && !redirect_valid) begin
      push_s = pc_legal_s && space_s;
    end else begin
      push_s = 1'b0;
    end
  end

  // Fetch FSM owning the PC and the sticky fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      fault_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r    <= redirect_pc;
      fault_r <= 1'b0;
      state_r <= fetch_en ? FETCH : IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fetch_en) begin
            state_r <= FETCH;
          end
        end
        FETCH: begin
          if (!fetch_en) begin
            state_r <= IDLE;
          end else if (!pc_legal_s) begin
            state_r <= FAULT;
          end else if (push_s) begin
            pc_r <= pc_r + PC_INCR;
          end
        end
        FAULT: begin
          // Report only once every older instruction has left the buffer.
          if (buf_count_s == '0) begin
            fault_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .wr_entry   (wr_entry_s),
    .count      (buf_count_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign imem_addr  = pc_r;
  assign inst_valid = head_valid_s;
  assign inst_data  = head_s.data;
  assign inst_pc    = head_s.pc;
  assign fault      = fault_r;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_flushed_r;
  logic [32:0] flushed_sum_s;

  assign flushed_sum_s = {1'b0, perf_flushed_r} + {{(33-CNT_W){1'b0}}, buf_count_s};

  // Saturating push and flush counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_r <= 32'd0;
      perf_flushed_r <= 32'd0;
    end else begin
      if (push_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed_r <= flushed_sum_s[32] ? 32'hFFFF_FFFF : flushed_sum_s[31:0];
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_flushed = perf_flushed_r;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected PCs, a negedge monitor checks deliveries.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1357_0000 | {24'd0, a[9:2]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fault          (fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_fault(input string name, input int limit);
    int k;
    k = 0;
    while (fault !== 1'b1 && k < limit) begin
      tick(1);
      k++;
    end
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL %s: fault=%b after %0d cycles, expected 1", name, fault, k);
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid"}, {31'd0, inst_valid}, 32'd0);
  endtask

  // Monitor: every accepted transfer must match the next expected PC.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h, expected no delivery", inst_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("inst_pc", inst_pc, mon_exp);
        check("inst_data", inst_data, mem_word(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    #12;
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_data", inst_data, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Stall with inst_ready low: two entries buffered, PC parked at 8.
    tick(1);
    fetch_en = 1'b1;
    tick(4);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_valid", {31'd0, inst_valid}, 32'd1);
    check("stall_pc", inst_pc, 32'h0);
    tick(1);
    check("hold_pc", inst_pc, 32'h0);
    check("hold_data", inst_data, mem_word(32'h0));
    check("hold_addr", imem_addr, 32'h8);

    // Release for exactly six transfers, then redirect with the buffer full.
    expect_seq(32'h0, 6);
    inst_ready = 1'b1;
    tick(6);
    pulse_redirect(32'h40);
    check("redir_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h40);

    // Run to the last word, then fault at 0xE0 after draining.
    expect_seq(32'h40, 40);
    wait_fault("end_of_mem", 80);
    check("fault_addr", imem_addr, 32'hE0);

    pulse_redirect(32'h0);
    check("fault_clear", {31'd0, fault}, 32'd0);
    expect_seq(32'h0, 3);
    tick(4);

    // Misaligned target: nothing delivered, fault raised.
    pulse_redirect(32'h42);
    wait_fault("misaligned", 10);
    check("misal_addr", imem_addr, 32'h42);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd52);
    check("perf_flushed", perf_flushed, 32'd3);
`endif

    // Asynchronous reset while faulted.
    #2 reset = 1'b1;
    #1;
    check("arst_fault", {31'd0, fault}, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    fetch_en = 1'b0; inst_ready = 1'b0;
    #3 reset = 1'b0;

    // Asynchronous reset mid-stream with a full buffer.
    tick(1);
    fetch_en = 1'b1;
    tick(5);
    check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mrst_valid", {31'd0, inst_valid}, 32'd0);
    check("mrst_pc", inst_pc, 32'd0);
    check("mrst_addr", imem_addr, 32'd0);
    fetch_en = 1'b0;
    #3 reset = 1'b0;

    // Drop fetch_en with two buffered entries: they drain and nothing more issues.
    tick(1);
    fetch_en = 1'b1;
    tick(5);
    expect_seq(32'h0, 2);
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    tick(6);
    check("drain_valid", {31'd0, inst_valid}, 32'd0);
    check("drain_addr", imem_addr, 32'h8);
`ifdef FETCH_PERF_EN
    check("perf_fetched_end", perf_fetched, 32'd2);
    check("perf_flushed_end", perf_flushed, 32'd0);
`endif
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
